// File: rtl/gray_encoder_arbiter.sv
// Round-robin arbiter sharing one 4-bit binary-to-Gray encoder among NUM_REQ requesters.
// Optional GRAY_ARB_SELFCHECK_EN adds a registered Gray decoder and sticky error flag.

module gray_code_encoder_subsystem (
  input  logic [3:0] i_bin,
  output logic [3:0] o_gray
);
  assign o_gray = i_bin ^ {1'b0, i_bin[3:1]};
endmodule

module gray_encoder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SRC_W   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [4*NUM_REQ-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic                   o_out_valid,
  output logic [3:0]             o_out_data,
  output logic [SRC_W-1:0]       o_out_src,
  input  logic                   i_out_ready,
  output logic                   o_busy
`ifdef GRAY_ARB_SELFCHECK_EN
  ,
  output logic                   o_err_sticky
`endif
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t                   r_state, w_state_nxt;
  logic [SRC_W-1:0]         r_last;
  logic                     r_out_valid;
  logic [3:0]               r_out_data;
  logic [SRC_W-1:0]         r_out_src;

  logic [NUM_REQ-1:0][3:0]  w_data;
  logic [NUM_REQ-1:0]       w_grant;
  logic [SRC_W-1:0]         w_win;
  logic                     w_any;
  logic                     w_acc;
  logic [3:0]               w_win_bin;
  logic [3:0]               w_gray;
  int                       w_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_data[g] = i_req_data[4*g +: 4];
  end

  // Search starts one past the last winner, so the previous winner is served last.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_last) + k) % NUM_REQ;
      if (!w_any && i_req_valid[w_idx[SRC_W-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[SRC_W-1:0];
      end
    end
  end

  assign w_grant     = w_any ? (NUM_REQ'(1) << w_win) : '0;
  assign o_req_ready = (r_state == S_IDLE && !i_reset) ? w_grant : '0;
  assign w_acc       = (r_state == S_IDLE) && w_any;
  assign w_win_bin   = w_data[w_win];

  gray_code_encoder_subsystem u_enc (
    .i_bin  (w_win_bin),
    .o_gray (w_gray)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nxt = S_BUSY;
      S_BUSY:  if (i_out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_last      <= SRC_W'(NUM_REQ-1);
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt == S_BUSY);
      if (w_acc) begin
        r_out_data <= w_gray;
        r_out_src  <= w_win;
        r_last     <= w_win;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_src   = r_out_src;
  assign o_busy      = (r_state == S_BUSY);

`ifdef GRAY_ARB_SELFCHECK_EN
  logic [3:0] r_bin, r_bin_q, r_dec, w_dec;
  logic       r_chk_vld, r_err;

  always_comb begin
    w_dec    = '0;
    w_dec[3] = r_out_data[3];
    for (int i = 2; i >= 0; i--) w_dec[i] = w_dec[i+1] ^ r_out_data[i];
  end

  // Decoded value and captured binary are both one cycle behind out_data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bin     <= '0;
      r_bin_q   <= '0;
      r_dec     <= '0;
      r_chk_vld <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_acc) r_bin <= w_win_bin;
      r_bin_q   <= r_bin;
      r_dec     <= w_dec;
      r_chk_vld <= r_out_valid;
      if (r_chk_vld && (r_dec != r_bin_q)) r_err <= 1'b1;
    end
  end

  assign o_err_sticky = r_err;
`endif

endmodule

// File: doc/gray_encoder_arbiter.md
Name: gray_encoder_arbiter

Overview:
- Shares one gray_code_encoder_subsystem instance (4-bit binary to 4-bit reflected Gray, purely combinational) between NUM_REQ requesters.
- Each requester offers a 4-bit binary word with valid/ready.
- Round-robin arbitration picks one request per transaction, encodes it, and holds the result in an output register with valid/ready until the consumer takes it.
- Sits between the lab's input sources (switch/UART/counter front ends) and the display/transmit back end.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SRC_W, 2, width of source index; must equal clog2(NUM_REQ), minimum 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  bit i = requester i offers data.
- req_data  input  4*NUM_REQ  requester i binary word at bits [4i+3:4i].
- req_ready  output  NUM_REQ  one-hot grant/accept; at most one bit set.
- out_valid  output  1  encoded result available.
- out_data  output  4  registered Gray code of the accepted word.
- out_src  output  SRC_W  index of the requester that produced out_data.
- out_ready  input  1  consumer accepts out_data this cycle.
- busy  output  1  high while a result is held (state BUSY).

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high. All outputs are 0 after reset. State is IDLE, last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM has two states, IDLE and BUSY.
- IDLE:
  - req_ready is combinational. If any req_valid bit is set, exactly one bit is asserted: the first set req_valid index searching last_grant+1, last_grant+2, … modulo NUM_REQ.
  - On that edge (req_valid & req_ready), the following are registered:
    - out_data <= encoder(req_data of winner);
    - out_src <= winner index;
    - last_grant <= winner;
    - out_valid <= 1;
    - state goes to BUSY.
  - No valid request: req_ready = 0, stay IDLE.
- BUSY:
  - req_ready = 0 for all requesters.
  - out_valid = 1; out_data and out_src are stable.
  - out_ready = 1: out_valid <= 0, state goes to IDLE.
  - out_ready = 0: hold indefinitely.
- Throughput and latency:
  - Maximum one transaction per 2 cycles (accept cycle, then drain cycle).
  - Result appears 1 cycle after acceptance.
- Requesters must hold req_valid and req_data stable until they see req_ready. The arbiter never drops an accepted word.
- A requester that deasserts req_valid before grant simply loses its turn. Nothing is stored.
- Encoding: gray = b ^ (b >> 1), e.g. 0000 -> 0000, 0101 -> 0111, 1010 -> 1111, 1111 -> 1000. The datapath must go through the shared encoder instance, not a duplicate.
- busy equals (state == BUSY), registered.
- Reset asserted mid-transaction (BUSY, out_ready low) discards the held result:
  - next cycle out_valid = 0, state IDLE, last_grant = NUM_REQ-1;
  - req_ready = 0 while reset is high.
- req_valid and out_ready both high in BUSY: only the drain happens; the new request is granted in the following IDLE cycle.
- last_grant updates only on accepted transactions.

Optional Feature:
- GRAY_ARB_SELFCHECK_EN
- Defined: adds a registered Gray-to-binary decoder on out_data (b[3]=g[3], b[i]=b[i+1]^g[i]) compared with the captured binary word. A mismatch sets output err_sticky (1 bit), which stays high until reset. err_sticky is 0 after reset and adds no latency to out_data.
- Undefined: no decoder, no err_sticky port; behaviour otherwise identical.

Test Plan:
- Reset, then req_valid=0001 with req_data[3:0]=0101 -> req_ready=0001 that cycle; next cycle out_valid=1, out_data=0111, out_src=0, busy=1; out_ready=1 -> out_valid=0 next cycle.
- All four requesters valid continuously with data 0001/0010/1010/1111, out_ready=1 -> grant order 0,1,2,3,0. out_data sequence is 0001, 0011, 1111, 1000, 0001, one result every 2 cycles.
- Backpressure: result 1111 held with out_ready=0 for 10 cycles -> out_data, out_src, out_valid stable and req_ready=0 throughout. Release -> next grant goes to last_grant+1.
- Exhaustive encode: requester 2 sends binary 0..15 -> out_data = 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000. Each has out_src=2.
- Reset in BUSY (out_data=1111, out_ready=0) -> next cycle out_valid=0, busy=0. Then requesters 1 and 3 valid -> requester 0 priority is restored, so requester 1 is granted first.
- With GRAY_ARB_SELFCHECK_EN: normal traffic -> err_sticky=0. Forcing out_data bit 0 inverted via bench force -> err_sticky=1 and held until reset.
